// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//
// Reads words from an external SPI NOR flash without firmware help. For each
// accepted request it drives one standard Read (0x03) command, sends a 24-bit
// start address, then clocks in (req_words + 1) 32-bit words. The flash
// auto-increments its address, so consecutive words need no new command.
// Words leave on a valid/ready stream, little-endian: the first byte received
// lands in rsp_data[7:0].
//
// Parameters
//   CLK_DIV   SCK half-period in wb_clk_i cycles (1..255)
//   CSB_HIGH  minimum wb_clk_i cycles CSB stays high between transactions (1..255)
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_ready is high only when idle
//   req_addr[23:0]              start byte address, any alignment
//   req_words[3:0]              burst length minus one
//   rsp_valid/rsp_ready         response handshake
//   rsp_data[31:0], rsp_last    response word and end-of-burst marker
//   busy                        high whenever a transaction is in flight
//   flash_csb, flash_clk        chip select (active low), SCK (mode 0)
//   flash_io0, flash_io0_oeb    MOSI and its active-low output enable
//   flash_io1                   MISO

module spi_flash_reader #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CSB_HIGH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [3:0]  req_words,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    output logic        flash_io0_oeb,
    input  logic        flash_io1
);

    localparam logic [7:0] DivLoad   = 8'(CLK_DIV - 1);
    localparam logic [7:0] DeselLoad = 8'(CSB_HIGH);
    localparam logic [7:0] ReadCmd   = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDesel
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;            // cycles left in the current SCK phase
    logic [4:0]  bit_q, bit_d;            // bit index inside CMD / ADDR / data word
    logic [3:0]  words_q, words_d;        // latched req_words
    logic [3:0]  word_idx_q, word_idx_d;  // index of the word being shifted in
    logic [30:0] tx_q, tx_d;              // remaining command/address bits, next at [30]
    logic [31:0] rx_q, rx_d;              // incoming word, first byte ends up in [31:24]
    logic        pend_q, pend_d;          // rx_q holds a complete word to publish
    logic        pend_last_q, pend_last_d;
    logic [7:0]  desel_q, desel_d;
    logic        csb_q, csb_d;
    logic        sck_q, sck_d;
    logic        io0_q, io0_d;
    logic        oeb_q, oeb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_last_q, rsp_last_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic shifting;
    logic hold_rise;
    logic rise;
    logic fall;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        words_d     = words_q;
        word_idx_d  = word_idx_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        desel_d     = desel_q;
        csb_d       = csb_q;
        sck_d       = sck_q;
        io0_d       = io0_q;
        oeb_d       = oeb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;

        shifting = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
        // Keep SCK low before the last bit of a word while the output slot is
        // still occupied; the word being assembled would otherwise overwrite it.
        hold_rise = (state_q == StData) && (bit_q == 5'd31) && rsp_valid_q && !rsp_ready;
        rise      = shifting && !sck_q && (div_q == 8'd0) && !hold_rise;
        fall      = shifting && sck_q && (div_q == 8'd0);

        // Output slot: a completed word is published one cycle after its last bit.
        if (pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            rsp_last_d  = pend_last_q;
            pend_d      = 1'b0;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
        end

        // SCK phase timing: low CLK_DIV cycles, then high CLK_DIV cycles.
        if (shifting) begin
            if (div_q != 8'd0) begin
                div_d = div_q - 8'd1;
            end else if (rise) begin
                sck_d = 1'b1;
                div_d = DivLoad;
            end else if (fall) begin
                sck_d = 1'b0;
                div_d = DivLoad;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d    = StCmd;
                    words_d    = req_words;
                    word_idx_d = 4'd0;
                    bit_d      = 5'd0;
                    tx_d       = {ReadCmd[6:0], req_addr};
                    io0_d      = ReadCmd[7];
                    csb_d      = 1'b0;
                    oeb_d      = 1'b0;
                    sck_d      = 1'b0;
                    div_d      = DivLoad;
                end
            end

            StCmd: begin
                if (fall) begin
                    io0_d = tx_q[30];
                    tx_d  = {tx_q[29:0], 1'b0};
                    if (bit_q == 5'd7) begin
                        state_d = StAddr;
                        bit_d   = 5'd0;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end

            StAddr: begin
                if (fall) begin
                    if (bit_q == 5'd23) begin
                        state_d = StData;
                        bit_d   = 5'd0;
                        oeb_d   = 1'b1;
                        io0_d   = 1'b0;
                    end else begin
                        io0_d = tx_q[30];
                        tx_d  = {tx_q[29:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                    end
                end
            end

            StData: begin
                // MISO is sampled on the edge that ends the high phase.
                if (fall) begin
                    rx_d  = {rx_q[30:0], flash_io1};
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd31) begin
                        pend_d      = 1'b1;
                        pend_last_d = (word_idx_q == words_q);
                        if (word_idx_q == words_q) begin
                            state_d = StDesel;
                            csb_d   = 1'b1;
                            oeb_d   = 1'b1;
                            desel_d = DeselLoad;
                        end else begin
                            word_idx_d = word_idx_q + 4'd1;
                        end
                    end
                end
            end

            StDesel: begin
                // Leave only once CSB has been high long enough and the last
                // word has been (or is being) taken by the consumer.
                if (desel_q != 8'd0) begin
                    desel_d = desel_q - 8'd1;
                end else if (!pend_q && (!rsp_valid_q || rsp_ready)) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            div_q       <= 8'd0;
            bit_q       <= 5'd0;
            words_q     <= 4'd0;
            word_idx_q  <= 4'd0;
            tx_q        <= 31'd0;
            rx_q        <= 32'd0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            desel_q     <= 8'd0;
            csb_q       <= 1'b1;
            sck_q       <= 1'b0;
            io0_q       <= 1'b0;
            oeb_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            words_q     <= words_d;
            word_idx_q  <= word_idx_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            desel_q     <= desel_d;
            csb_q       <= csb_d;
            sck_q       <= sck_d;
            io0_q       <= io0_d;
            oeb_q       <= oeb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready     = (state_q == StIdle) && !wb_rst_i;
    assign busy          = (state_q != StIdle);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_last      = rsp_last_q;
    assign flash_csb     = csb_q;
    assign flash_clk     = sck_q;
    assign flash_io0     = io0_q;
    assign flash_io0_oeb = oeb_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2/CSB_HIGH=4 and
// CLK_DIV=1/CSB_HIGH=1) each talking to a behavioural SPI flash.
module tb_spi_flash_reader;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [23:0] req_addr  [2];
    logic [3:0]  req_words [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_last  [2];
    logic        busy      [2];
    logic        csb       [2];
    logic        sck       [2];
    logic        io0       [2];
    logic        oeb       [2];
    logic        io1       [2];

    int total;
    int bad;

    spi_flash_reader #(.CLK_DIV(2), .CSB_HIGH(4)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_words(req_words[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_last(rsp_last[0]), .busy(busy[0]),
        .flash_csb(csb[0]), .flash_clk(sck[0]), .flash_io0(io0[0]),
        .flash_io0_oeb(oeb[0]), .flash_io1(io1[0])
    );

    spi_flash_reader #(.CLK_DIV(1), .CSB_HIGH(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_words(req_words[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_last(rsp_last[1]), .busy(busy[1]),
        .flash_csb(csb[1]), .flash_clk(sck[1]), .flash_io0(io0[1]),
        .flash_io0_oeb(oeb[1]), .flash_io1(io1[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flash image: 0x100..0x107 = 11 22 .. 88, elsewhere an address hash.
    function automatic logic [7:0] byte_at(input logic [23:0] a);
        if (a >= 24'h000100 && a <= 24'h000107) return 8'((a - 24'h0000FF) * 17);
        return a[7:0] ^ (a[15:8] + 8'h3C) ^ {a[20:16], a[23:21]};
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {byte_at(a + 24'd3), byte_at(a + 24'd2), byte_at(a + 24'd1), byte_at(a)};
    endfunction

    // Behavioural flash, observed once per cycle away from the active edge.
    int          fl_bits    [2];
    logic [31:0] fl_hdr     [2];
    logic        sck_prev   [2];
    int          data_rises [2];
    int          oeb_err    [2];
    int          fm_d;
    logic [23:0] fm_a;
    logic [7:0]  fm_b;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (csb[i] !== 1'b0) begin
                fl_bits[i] = 0;
                io1[i] = 1'b0;
            end else if (sck[i] && !sck_prev[i]) begin
                if (fl_bits[i] < 32) begin
                    fl_hdr[i] = {fl_hdr[i][30:0], io0[i]};
                    if (oeb[i] !== 1'b0) oeb_err[i]++;
                end else begin
                    data_rises[i]++;
                    if (oeb[i] !== 1'b1) oeb_err[i]++;
                end
                fl_bits[i]++;
            end else if (!sck[i] && sck_prev[i] && fl_bits[i] >= 32) begin
                fm_d = fl_bits[i] - 32;
                fm_a = fl_hdr[i][23:0] + 24'(fm_d / 8);
                fm_b = byte_at(fm_a);
                io1[i] = fm_b[7 - (fm_d % 8)];
            end
            sck_prev[i] = sck[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          inst;
        logic [23:0] addr;
        logic [3:0]  words;
        int          pct;    // rsp_ready probability in percent
        int          stall;  // cycles of rsp_ready=0 after the first rsp_valid
        bit          poke;   // pulse req_valid while busy
        logic [31:0] first;  // expected first word
        int          lat;    // expected accept -> first rsp_valid cycles
        int          idle;   // expected accept -> req_ready cycles, -1 = unchecked
    } vec_t;

    function automatic vec_t mk(input int inst, input logic [23:0] addr, input logic [3:0] words,
                                input int pct, input int stall, input bit poke,
                                input logic [31:0] first, input int lat, input int idle);
        vec_t v;
        v.inst = inst; v.addr = addr; v.words = words; v.pct = pct; v.stall = stall;
        v.poke = poke; v.first = first; v.lat = lat; v.idle = idle;
        return v;
    endfunction

    task automatic do_read(input vec_t v);
        int i, w, n, got, stall_cnt, rises0, oeb0;
        bit seen, done, stable;
        logic [31:0] exp_w;
        i = v.inst;
        w = 0;
        while (req_ready[i] !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        rises0 = data_rises[i];
        oeb0 = oeb_err[i];
        req_addr[i] = v.addr;
        req_words[i] = v.words;
        req_valid[i] = 1'b1;
        rsp_ready[i] = ($urandom_range(99) < v.pct);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        n = 0; got = 0; stall_cnt = 0; seen = 0; done = 0; stable = 1;
        while (!done && n < 30000) begin
            @(negedge clk);
            if (v.poke && n == 10) begin
                check("req_ready_while_busy", 32'(req_ready[i]), 0);
                req_valid[i] = 1'b1;
                req_addr[i] = ~v.addr;
            end
            if (v.poke && n == 14) begin
                req_valid[i] = 1'b0;
                req_addr[i] = v.addr;
            end
            if (rsp_valid[i] && !seen) begin
                seen = 1;
                check("first_word_latency", n, v.lat);
            end
            if (seen && stall_cnt < v.stall) begin
                rsp_ready[i] = 1'b0;
                if (rsp_data[i] !== v.first) stable = 0;
                stall_cnt++;
                if (stall_cnt == v.stall) begin
                    check("bp_data_stable", 32'(stable), 1);
                    check("bp_valid_held", 32'(rsp_valid[i]), 1);
                    check("bp_csb_low", 32'(csb[i]), 0);
                    check("bp_sck_low", 32'(sck[i]), 0);
                    check("bp_sck_rises_frozen", data_rises[i] - rises0, 63);
                end
            end else begin
                rsp_ready[i] = ($urandom_range(99) < v.pct);
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
                if (got > int'(v.words)) begin
                    check("extra_word", got, 32'(v.words));
                end else begin
                    exp_w = word_at(v.addr + 24'(4 * got));
                    if (got == 0) check("first_word_table", rsp_data[i], v.first);
                    check("word_data", rsp_data[i], exp_w);
                    check("word_last", 32'(rsp_last[i]), 32'(got == int'(v.words)));
                end
                got++;
            end
            if (got > int'(v.words) && req_ready[i]) begin
                done = 1;
                if (v.idle >= 0) check("accept_to_ready", n, v.idle);
            end
            n++;
        end
        rsp_ready[i] = 1'b0;
        check("completed", 32'(done), 1);
        check("word_count", got, int'(v.words) + 1);
        check("mosi_cmd_addr", fl_hdr[i], {8'h03, v.addr});
        check("data_sck_rises", data_rises[i] - rises0, 32 * (int'(v.words) + 1));
        check("oeb_during_bits", oeb_err[i] - oeb0, 0);
        check("idle_csb", 32'(csb[i]), 1);
        check("idle_sck", 32'(sck[i]), 0);
        check("idle_oeb", 32'(oeb[i]), 1);
        check("idle_busy", 32'(busy[i]), 0);
        check("idle_rsp_valid", 32'(rsp_valid[i]), 0);
    endtask

    vec_t vecs[$];

    initial begin
        int inst, dv, ch, pct;
        logic [23:0] a;
        logic [3:0] wd;
        total = 0;
        bad = 0;

        // Fixed vectors from the datasheet-style examples, then random ones.
        vecs.push_back(mk(0, 24'h000100, 4'd0, 100, 0, 0, 32'h44332211, 257, 261));
        vecs.push_back(mk(0, 24'h000100, 4'd1, 100, 0, 0, 32'h44332211, 257, 389));
        vecs.push_back(mk(1, 24'h000101, 4'd0, 100, 0, 1, 32'h55443322, 129, 130));
        vecs.push_back(mk(0, 24'h000200, 4'd3, 100, 500, 0, word_at(24'h000200), 257, -1));
        for (int k = 0; k < 6; k++) begin
            inst = int'($urandom_range(1));
            a = 24'($urandom);
            wd = 4'($urandom_range(5));
            pct = (k < 2) ? 100 : int'($urandom_range(100, 30));
            dv = (inst == 0) ? 2 : 1;
            ch = (inst == 0) ? 4 : 1;
            vecs.push_back(mk(inst, a, wd, pct, 0, bit'($urandom_range(1)), word_at(a),
                              128 * dv + 1,
                              (pct == 100) ? 128 * dv + 64 * dv * int'(wd) + ch + 1 : -1));
        end

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i] = 24'd0;
            req_words[i] = 4'd0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", 32'(req_ready[i]), 0);
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_rsp_valid", 32'(rsp_valid[i]), 0);
            check("rst_rsp_last", 32'(rsp_last[i]), 0);
            check("rst_rsp_data", rsp_data[i], 0);
            check("rst_csb", 32'(csb[i]), 1);
            check("rst_sck", 32'(sck[i]), 0);
            check("rst_io0", 32'(io0[i]), 0);
            check("rst_oeb", 32'(oeb[i]), 1);
        end
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_rst", 32'(req_ready[0]), 1);
        check("req_ready_after_rst_1", 32'(req_ready[1]), 1);

        for (int k = 0; k < vecs.size(); k++) do_read(vecs[k]);

        // Reset during the address phase of a 4-word read.
        req_addr[0] = 24'h000300;
        req_words[0] = 4'd3;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (60) @(negedge clk);
        check("mid_addr_csb_low", 32'(csb[0]), 0);
        check("mid_addr_busy", 32'(busy[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_csb", 32'(csb[0]), 1);
        check("midrst_sck", 32'(sck[0]), 0);
        check("midrst_rsp_valid", 32'(rsp_valid[0]), 0);
        check("midrst_busy", 32'(busy[0]), 0);
        check("midrst_oeb", 32'(oeb[0]), 1);
        check("midrst_req_ready", 32'(req_ready[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_req_ready", 32'(req_ready[0]), 1);
        do_read(mk(0, 24'h000300, 4'd3, 100, 0, 0, word_at(24'h000300), 257,
                   256 + 128 * 3 + 5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
